// File: rtl/i2c_rr_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_rr_arbiter
//
// Shares one byte-level I2C master among N_REQ requesters. Requesters are
// served round-robin. Each grant runs exactly one master transaction
// {7-bit address, rw, one data byte}. The result goes back to the served
// requester as a one-cycle tagged response. Two timeouts protect against a
// stuck master:
//   - the master must drop i2c_ready within ACCEPT_TO cycles of enable.
//   - the master must raise i2c_ready within DONE_TO cycles once busy.
// The master itself is never reset by this block.
//
// Ports
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   req               per-requester level request, held until its done pulse
//   req_addr          7-bit slave address per requester, [7i+6:7i]
//   req_rw            per-requester direction, 1 = read
//   req_wdata         write byte per requester, [8i+7:8i]
//   done              one-hot, one-cycle pulse to the served requester
//   rsp_valid         one-cycle pulse, coincident with done
//   rsp_id            index of the served requester (zero-extended)
//   rsp_rdata         read byte; 0 for writes and on timeout
//   rsp_err           timeout on this transaction
//   busy              high from ISSUE through RESP inclusive
//   i2c_addr/rw/
//   i2c_data_in       transaction fields to the master, stable until next grant
//   i2c_enable        master enable, high only while issuing
//   i2c_ready         master idle indication
//   i2c_data_out      master read byte
// ---------------------------------------------------------------------------
module i2c_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ACCEPT_TO = 64,
    parameter int DONE_TO   = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     done,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_id,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [6:0]           i2c_addr,
    output logic                 i2c_rw,
    output logic [7:0]           i2c_data_in,
    output logic                 i2c_enable,
    input  logic                 i2c_ready,
    input  logic [7:0]           i2c_data_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [15:0] ACCEPT_LAST = 16'(ACCEPT_TO - 1);
    localparam logic [15:0] DONE_LAST   = 16'(DONE_TO - 1);
    localparam logic [2:0]  LAST_ID     = 3'(N_REQ - 1);

    state_t      state;
    logic [2:0]  rr_ptr;
    logic [2:0]  cur_id;
    logic [15:0] timer;

    // Requester fields padded out to eight slots so that a 3-bit index
    // always selects an existing entry; slots >= N_REQ read as zero.
    logic [7:0] req8;
    logic [7:0] rw8;
    logic [6:0] addr_arr  [8];
    logic [7:0] wdata_arr [8];

    assign req8 = 8'(req);
    assign rw8  = 8'(req_rw);

    for (genvar j = 0; j < 8; j++) begin : g_unpack
        if (j < N_REQ) begin : g_real
            assign addr_arr[j]  = req_addr[7*j +: 7];
            assign wdata_arr[j] = req_wdata[8*j +: 8];
        end else begin : g_pad
            assign addr_arr[j]  = '0;
            assign wdata_arr[j] = '0;
        end
    end

    // Round-robin search: walk from rr_ptr+1 (mod N_REQ) and take the first
    // set request. The requester just served is therefore checked last.
    logic [2:0] pick_id;
    logic       pick_found;
    logic [2:0] cand;

    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        cand       = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (cand == LAST_ID) cand = '0;
            else                 cand = cand + 3'd1;
            if (!pick_found && req8[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    logic [N_REQ-1:0] done_nxt;

    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            done_nxt[j] = (cur_id == 3'(j));
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] t);
        return (t == 16'hFFFF) ? t : t + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= LAST_ID;
            cur_id      <= '0;
            timer       <= '0;
            i2c_enable  <= 1'b0;
            done        <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            i2c_addr    <= '0;
            i2c_rw      <= 1'b0;
            i2c_data_in <= '0;
        end else begin
            // Response outputs are pulses; they are only set on entry to RESP.
            done      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    i2c_enable <= 1'b0;
                    busy       <= 1'b0;
                    // No grant while the master is still busy (for example
                    // finishing an op that timed out on our side).
                    if (pick_found && i2c_ready) begin
                        cur_id      <= pick_id;
                        rr_ptr      <= pick_id;
                        i2c_addr    <= addr_arr[pick_id];
                        i2c_rw      <= rw8[pick_id];
                        i2c_data_in <= wdata_arr[pick_id];
                        timer       <= '0;
                        i2c_enable  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!i2c_ready) begin
                        // Master accepted; drop enable immediately so it does
                        // not chain a repeated start.
                        timer      <= '0;
                        i2c_enable <= 1'b0;
                        state      <= WAIT_DONE;
                    end else if (timer == ACCEPT_LAST) begin
                        i2c_enable <= 1'b0;
                        done       <= done_nxt;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_err    <= 1'b1;
                        state      <= RESP;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end

                WAIT_DONE: begin
                    i2c_enable <= 1'b0;
                    if (i2c_ready) begin
                        done      <= done_nxt;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_rdata <= i2c_rw ? i2c_data_out : 8'h00;
                        state     <= RESP;
                    end else if (timer == DONE_LAST) begin
                        done      <= done_nxt;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end

                RESP: begin
                    i2c_enable <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    i2c_enable <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_rr_arbiter.sv
module tb_i2c_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_wdata;
    logic [3:0]  done;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [6:0]  i2c_addr;
    logic        i2c_rw;
    logic [7:0]  i2c_data_in;
    logic        i2c_enable;
    logic        i2c_ready;
    logic [7:0]  i2c_data_out;

    i2c_rr_arbiter #(
        .N_REQ    (4),
        .ACCEPT_TO(64),
        .DONE_TO  (2048)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .done        (done),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .i2c_addr    (i2c_addr),
        .i2c_rw      (i2c_rw),
        .i2c_data_in (i2c_data_in),
        .i2c_enable  (i2c_enable),
        .i2c_ready   (i2c_ready),
        .i2c_data_out(i2c_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Master model controls: accept after m_acc enable-high cycles (0 = never),
    // stay busy for m_busy cycles, then present m_rdata.
    int         m_acc   = 1;
    int         m_busy  = 2;
    logic [7:0] m_rdata = 8'h00;
    int         m_phase;
    int         m_en;
    int         m_cnt;
    int         m_len;

    initial begin
        i2c_ready    = 1'b1;
        i2c_data_out = 8'h00;
        m_phase = 0;
        m_en    = 0;
        m_cnt   = 0;
        m_len   = 0;
        forever begin
            @(negedge clk);
            if (m_phase == 0) begin
                if (i2c_enable) begin
                    m_en++;
                    if (m_acc != 0 && m_en == m_acc) begin
                        i2c_ready = 1'b0;
                        m_phase   = 1;
                        m_cnt     = 0;
                        m_len     = m_busy;
                        m_en      = 0;
                    end
                end else begin
                    m_en = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt >= m_len) begin
                    i2c_ready    = 1'b1;
                    i2c_data_out = m_rdata;
                    m_phase      = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations collected while waiting for a response.
    int         en_hi;
    int         wd_cyc;
    bit         cap_seen;
    logic [6:0] cap_addr;
    logic [7:0] cap_wdata;
    logic       cap_rw;

    task automatic wait_rsp(input int budget, input string name, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        en_hi = 0;
        wd_cyc = 0;
        cap_seen = 1'b0;
        cap_addr = '0;
        cap_wdata = '0;
        cap_rw = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (i2c_enable) begin
                en_hi++;
                if (!cap_seen) begin
                    cap_seen  = 1'b1;
                    cap_addr  = i2c_addr;
                    cap_wdata = i2c_data_in;
                    cap_rw    = i2c_rw;
                end
            end
            if (busy && !i2c_enable && !rsp_valid) wd_cyc++;
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no rsp_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic check_rsp(input string name, input logic [2:0] eid,
                             input logic [7:0] erd, input logic eerr);
        logic [3:0] oh;
        oh = 4'b0001 << eid;
        check({name, " rsp_id"},    32'(rsp_id),    32'(eid));
        check({name, " done"},      32'(done),      32'(oh));
        check({name, " rsp_rdata"}, 32'(rsp_rdata), 32'(erd));
        check({name, " rsp_err"},   32'(rsp_err),   32'(eerr));
    endtask

    typedef struct {
        logic [3:0] vreq;
        logic [3:0] vrw;
        int         acc;
        int         blen;
        logic [7:0] mdata;
        logic [2:0] exp_id;
        logic [6:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit         ok;
        int         cnt;
        int         n;
        logic [2:0] rr_exp [5];

        // Fixed per-requester fields: r0 0x48/A5, r1 0x50/3B, r2 0x2A/C6, r3 0x11/0F.
        req_addr  = {7'h11, 7'h2A, 7'h50, 7'h48};
        req_wdata = {8'h0F, 8'hC6, 8'h3B, 8'hA5};
        req       = 4'b0000;
        req_rw    = 4'b0000;
        rst_n     = 1'b0;

        // Round-robin pointer after the single-requester test below is 0.
        vecs[0] = '{4'b0010, 4'b0010, 2, 10, 8'h3C, 3'd1, 7'h50, 8'h3B, 8'h3C, 1'b0};
        vecs[1] = '{4'b0011, 4'b0000, 1, 5,  8'h99, 3'd0, 7'h48, 8'hA5, 8'h00, 1'b0};
        vecs[2] = '{4'b1001, 4'b1111, 3, 7,  8'h5A, 3'd3, 7'h11, 8'h0F, 8'h5A, 1'b0};
        vecs[3] = '{4'b1100, 4'b0100, 1, 4,  8'hE7, 3'd2, 7'h2A, 8'hC6, 8'hE7, 1'b0};
        vecs[4] = '{4'b0100, 4'b0000, 2, 3,  8'h81, 3'd2, 7'h2A, 8'hC6, 8'h00, 1'b0};
        vecs[5] = '{4'b1000, 4'b1000, 1, 1,  8'hFF, 3'd3, 7'h11, 8'h0F, 8'hFF, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset i2c_enable", 32'(i2c_enable), 32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset done",       32'(done),       32'd0);
        check("reset rsp_valid",  32'(rsp_valid),  32'd0);
        check("reset i2c_addr",   32'(i2c_addr),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 0: accept after 3, busy 80
        m_acc = 3; m_busy = 80; m_rdata = 8'h77;
        req_rw = 4'b0000;
        req = 4'b0001;
        wait_rsp(400, "t1", ok);
        if (ok) begin
            check("t1 enable cycles", 32'(en_hi),  32'd3);
            check("t1 wait cycles",   32'(wd_cyc), 32'd80);
            check("t1 addr",          32'(cap_addr),  32'h48);
            check("t1 wdata",         32'(cap_wdata), 32'hA5);
            check("t1 busy in resp",  32'(busy), 32'd1);
            check_rsp("t1", 3'd0, 8'h00, 1'b0);
        end
        req = 4'b0000;
        @(negedge clk);
        check("t1 rsp_valid pulse", 32'(rsp_valid), 32'd0);
        check("t1 busy after",      32'(busy),      32'd0);

        // Table-driven transactions
        foreach (vecs[i]) begin
            m_acc = vecs[i].acc; m_busy = vecs[i].blen; m_rdata = vecs[i].mdata;
            req_rw = vecs[i].vrw;
            req = vecs[i].vreq;
            wait_rsp(400, $sformatf("v%0d", i), ok);
            if (ok) begin
                check_rsp($sformatf("v%0d", i), vecs[i].exp_id, vecs[i].exp_rdata, vecs[i].exp_err);
                check($sformatf("v%0d addr", i),  32'(cap_addr),  32'(vecs[i].exp_addr));
                check($sformatf("v%0d wdata", i), 32'(cap_wdata), 32'(vecs[i].exp_wdata));
                check($sformatf("v%0d rw", i),    32'(cap_rw),    32'(vecs[i].vrw[vecs[i].exp_id]));
            end
            req = 4'b0000;
            @(negedge clk);
            check($sformatf("v%0d rsp_valid pulse", i), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d addr hold", i),       32'(i2c_addr),  32'(vecs[i].exp_addr));
        end

        // All requests held: last served was 3, so rotation 0,1,2,3,0
        rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        m_acc = 1; m_busy = 2; m_rdata = 8'h00;
        req_rw = 4'b0000;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(100, $sformatf("rr%0d", k), ok);
            if (ok) check($sformatf("rr%0d id", k), 32'(rsp_id), 32'(rr_exp[k]));
        end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // Accept timeout: master never drops ready
        m_acc = 0; m_rdata = 8'h66;
        req_rw = 4'b0001;
        req = 4'b0001;
        wait_rsp(200, "acc_to", ok);
        if (ok) begin
            check("acc_to enable cycles", 32'(en_hi),      32'd64);
            check("acc_to enable low",    32'(i2c_enable), 32'd0);
            check_rsp("acc_to", 3'd0, 8'h00, 1'b1);
        end
        req = 4'b0000;
        @(negedge clk);
        check("acc_to idle busy", 32'(busy), 32'd0);

        // Done timeout: master stays busy for 5000 cycles
        m_acc = 1; m_busy = 5000; m_rdata = 8'h3C;
        req_rw = 4'b0010;
        req = 4'b0010;
        wait_rsp(3000, "done_to", ok);
        if (ok) begin
            check("done_to wait cycles", 32'(wd_cyc), 32'd2048);
            check_rsp("done_to", 3'd1, 8'h00, 1'b1);
        end
        // New request while the master is still busy must not be granted.
        m_acc = 1; m_busy = 3; m_rdata = 8'h44;
        req_rw = 4'b0000;
        req = 4'b0001;
        cnt = 0;
        n = 0;
        while (!i2c_ready && n < 4000) begin
            @(negedge clk);
            n++;
            if (!i2c_ready && (i2c_enable || busy)) cnt++;
        end
        check("master busy no grant", 32'(cnt), 32'd0);
        check("master busy bounded",  32'(i2c_ready), 32'd1);
        wait_rsp(100, "after_to", ok);
        if (ok) check_rsp("after_to", 3'd0, 8'h00, 1'b0);
        req = 4'b0000;
        @(negedge clk);

        // Reset during WAIT_DONE
        m_acc = 2; m_busy = 40; m_rdata = 8'h12;
        req_rw = 4'b0000;
        req = 4'b0100;
        n = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            @(negedge clk);
            n++;
            if (busy && !i2c_enable) ok = 1'b1;
        end
        check("rst reached wait_done", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        check("rst busy",        32'(busy),        32'd0);
        check("rst i2c_enable",  32'(i2c_enable),  32'd0);
        check("rst done",        32'(done),        32'd0);
        check("rst rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst i2c_addr",    32'(i2c_addr),    32'd0);
        check("rst i2c_data_in", 32'(i2c_data_in), 32'd0);
        check("rst i2c_rw",      32'(i2c_rw),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rsp_valid || done != 4'b0000) cnt++;
        end
        check("rst no done pulse", 32'(cnt), 32'd0);
        m_acc = 1; m_busy = 2; m_rdata = 8'h00;
        req = 4'b1111;
        wait_rsp(100, "rst_rereq", ok);
        if (ok) check("rst rereq id", 32'(rsp_id), 32'd0);
        req = 4'b0000;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
